// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: memory geometry,
// word width and the loader FSM state encoding.
package imem_pkg;

    localparam int IMEM_DEPTH     = 100;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four big-endian bytes into one 32-bit word. The first byte of a
// word ends up in bits [31:24]. word_valid pulses on the transfer that
// completes a word. The word register holds its value until the next shift,
// so the parent can write it out in the following cycle.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Next-state logic: clear discards a partial word; a transfer shifts in one byte.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (shift_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[WORD_W-9:0], byte_in};
        end
    end

    // Byte counter and shift register, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word       = word_q;
    assign word_valid = shift_en && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader. It takes a program as a byte stream and writes
// it into the instruction memory one word at a time, starting at BASE_ADDR.
// The core is held while a load runs. At the end the loader reports done or
// err, plus a mod-2^32 checksum of the words it wrote.
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
// byte_ready is high only while receiving, and never while an abort is
// present. byte_valid may drop at any time, for as long as the source likes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_words,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] checksum,
    output imem_state_t       dbg_state
);

    localparam logic [ADDR_W-1:0] MAX_WORDS = ADDR_W'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    imem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [WORD_W-1:0] checksum_q, checksum_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              packer_clear;
    logic              shift_en;
    logic              word_valid;
    logic [WORD_W-1:0] packed_word;

    // An abort is present while a load is in progress, that is, in any state other than IDLE.
    logic              abort_now;
    assign abort_now = load_abort && (state_q != ST_IDLE);

    assign byte_ready = (state_q == ST_RECV) && !abort_now;
    assign shift_en   = byte_valid && byte_ready;
    assign wr_en      = (state_q == ST_WRITE) && !abort_now;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (packer_clear),
        .shift_en   (shift_en),
        .byte_in    (byte_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    // FSM next-state and counter updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        remaining_d  = remaining_q;
        checksum_d   = checksum_q;
        done_d       = done_q;
        err_d        = err_q;
        cpu_hold_d   = cpu_hold_q;
        packer_clear = 1'b0;

        if (abort_now) begin
            state_d      = ST_IDLE;
            cpu_hold_d   = 1'b0;
            err_d        = 1'b1;
            done_d       = 1'b0;
            packer_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        if (load_words > MAX_WORDS) begin
                            err_d  = 1'b1;
                            done_d = 1'b0;
                        end else if (load_words == '0) begin
                            done_d     = 1'b1;
                            err_d      = 1'b0;
                            checksum_d = '0;
                        end else begin
                            remaining_d = load_words;
                            wr_addr_d   = BASE_A;
                            checksum_d  = '0;
                            done_d      = 1'b0;
                            err_d       = 1'b0;
                            cpu_hold_d  = 1'b1;
                            state_d     = ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_valid) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    checksum_d  = checksum_q + packed_word;
                    remaining_d = remaining_q - ONE_A;
                    if (remaining_q == ONE_A) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        wr_addr_d = wr_addr_q + ONE_A;
                        state_d   = ST_RECV;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and status flags, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= BASE_A;
            remaining_q <= '0;
            checksum_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            remaining_q <= remaining_d;
            checksum_q  <= checksum_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = packed_word;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign checksum  = checksum_q;
    assign dbg_state = state_q;

endmodule
